// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - Bundle of client request, response and ALU-side signals for alu_sequencer
//
// Purpose: groups the two request channels, the response channel and the
// external ALU connection into one interface.
//   slave  modport : seen by alu_sequencer (accepts requests, drives ALU, returns results)
//   master modport : seen by the environment (clients, consumer and the ALU itself)
// Signals:
//   req0_*/req1_* : valid/ready handshake plus a, b, op, cnt for each client
//   rsp_*         : valid/ready handshake plus data, cout, id of the finished operation
//   alu_a/b/op    : operands and opcode to the shared ALU
//   alu_c/cout    : ALU result and carry/overflow back to the sequencer

interface alu_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [3:0]       req0_op;
  logic [CNT_W-1:0] req0_cnt;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       req1_op;
  logic [CNT_W-1:0] req1_cnt;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_cout;
  logic             rsp_id;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_c;
  logic             alu_cout;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_cnt,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, req1_cnt,
    output req1_ready,
    output rsp_valid, rsp_data, rsp_cout, rsp_id,
    input  rsp_ready,
    output alu_a, alu_b, alu_op,
    input  alu_c, alu_cout
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_cnt,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op, req1_cnt,
    input  req1_ready,
    input  rsp_valid, rsp_data, rsp_cout, rsp_id,
    output rsp_ready,
    input  alu_a, alu_b, alu_op,
    output alu_c, alu_cout
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - Round-robin sharing of one ALU with repeat-count feedback of the result
//
// Purpose: accepts an operation from one of two clients, runs it on the
// external ALU cnt times (cnt==0 means once) with the ALU result fed back
// into operand A, then presents the final result on the response channel.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : alu_sequencer_if.slave (requests, response, ALU connection)
//   busy    : high while an operation is executing or awaiting response handshake

module alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  alu_sequencer_if.slave bus,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_next;

  logic             last_grant;
  logic             id;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       op_reg;
  logic [CNT_W-1:0] remaining;
  logic             cout_acc;

  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic             rsp_cout_r;
  logic             rsp_id_r;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             last_iter;

  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_op;
  logic [CNT_W-1:0] sel_cnt;

  assign last_iter = (remaining == CNT_ONE);
  assign accept    = grant0 | grant1;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and grant. When both clients ask, the one that did not win
  // last time gets the ALU; last_grant resets to 1 so client 0 wins first.
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0_valid && (!bus.req1_valid || last_grant)) begin
          grant0 = 1'b1;
        end else if (bus.req1_valid) begin
          grant1 = 1'b1;
        end
        if (grant0 || grant1) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (last_iter) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Fields of the granted client
  always_comb begin
    sel_a   = bus.req0_a;
    sel_b   = bus.req0_b;
    sel_op  = bus.req0_op;
    sel_cnt = bus.req0_cnt;
    if (grant1) begin
      sel_a   = bus.req1_a;
      sel_b   = bus.req1_b;
      sel_op  = bus.req1_op;
      sel_cnt = bus.req1_cnt;
    end
  end

  // Operation registers and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant  <= 1'b1;
      id          <= 1'b0;
      acc         <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      remaining   <= '0;
      cout_acc    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_cout_r  <= 1'b0;
      rsp_id_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc        <= sel_a;
            b_reg      <= sel_b;
            op_reg     <= sel_op;
            id         <= grant1;
            last_grant <= grant1;
            cout_acc   <= 1'b0;
            remaining  <= (sel_cnt == '0) ? CNT_ONE : sel_cnt;
          end
        end
        EXEC: begin
          // Result feeds back into operand A for the next iteration
          acc       <= bus.alu_c;
          cout_acc  <= cout_acc | bus.alu_cout;
          remaining <= remaining - CNT_ONE;
          if (last_iter) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= bus.alu_c;
            rsp_cout_r  <= cout_acc | bus.alu_cout;
            rsp_id_r    <= id;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ALU is driven straight from the operation registers, so its inputs stay
  // stable within each EXEC cycle and simply hold outside EXEC.
  assign bus.alu_a  = acc;
  assign bus.alu_b  = b_reg;
  assign bus.alu_op = op_reg;

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_cout  = rsp_cout_r;
  assign bus.rsp_id    = rsp_id_r;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - Directed vector bench for alu_sequencer with a behavioural ALU

module tb_alu_sequencer;

  logic clk;
  logic reset_n;
  logic busy;

  int applied;
  int miscompares;

  alu_sequencer_if #(.WIDTH(16), .CNT_W(4)) bus ();

  alu_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: 0000 ADD, 0001 SUB (cout = signed overflow), 0010 AND,
  // 0011 OR, 0100 XOR, 1001 NOT, 1101 SHL (cout = bit out), 1110 SHR,
  // 1111 ROTL; anything else passes A.
  always_comb begin
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        co;
    a  = bus.alu_a;
    b  = bus.alu_b;
    r  = a;
    co = 1'b0;
    case (bus.alu_op)
      4'b0000: begin r = a + b; co = (a[15] == b[15]) && (r[15] != a[15]); end
      4'b0001: begin r = a - b; co = (a[15] != b[15]) && (r[15] != a[15]); end
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b1001: r = ~a;
      4'b1101: begin r = {a[14:0], 1'b0}; co = a[15]; end
      4'b1110: r = {1'b0, a[15:1]};
      4'b1111: r = {a[14:0], a[15]};
      default: r = a;
    endcase
    bus.alu_c    = r;
    bus.alu_cout = co;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [3:0]  cnt;
    logic [15:0] exp_data;
    logic        exp_cout;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  task automatic drive_req(input logic cid, input logic v, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] op, input logic [3:0] cnt);
    if (cid == 1'b0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_cnt = cnt;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_cnt = cnt;
    end
  endtask

  // Presents one request, waits for its acceptance and then for rsp_valid.
  // Latency counts cycles from the accept cycle to the first cycle with rsp_valid.
  task automatic do_op(input string tag, input logic cid, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op, input logic [3:0] cnt,
                       output logic [15:0] data, output logic cout, output logic rid,
                       output int lat, output logic ok);
    int waited;
    logic seen;
    ok = 1'b0; data = '0; cout = 1'b0; rid = 1'b0; lat = 0;
    @(posedge clk); #1;
    drive_req(cid, 1'b1, a, b, op, cnt);
    seen = 1'b0;
    for (waited = 0; waited < 50 && !seen; waited++) begin
      @(negedge clk);
      seen = (cid == 1'b0) ? bus.req0_ready : bus.req1_ready;
    end
    if (!seen) begin
      check({tag, " accept timeout"}, 32'd0, 32'd1);
      drive_req(cid, 1'b0, a, b, op, cnt);
      return;
    end
    @(posedge clk); #1;
    drive_req(cid, 1'b0, a, b, op, cnt);
    seen = 1'b0;
    for (waited = 0; waited < 40 && !seen; waited++) begin
      @(negedge clk);
      lat++;
      seen = bus.rsp_valid;
    end
    if (!seen) begin
      check({tag, " rsp timeout"}, 32'd0, 32'd1);
      return;
    end
    data = bus.rsp_data; cout = bus.rsp_cout; rid = bus.rsp_id;
    ok = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    logic        c;
    logic        r;
    logic        ok;
    int          lat;
    int          acc_ids [4];
    int          acc_cyc [4];
    int          n_acc;
    int          both_ready;
    int          rsp_seen;

    applied = 0;
    miscompares = 0;

    vecs[0] = '{1'b0, 16'h7FFF, 16'h0001, 4'b0000, 4'd1,  16'h8000, 1'b1, 2};
    vecs[1] = '{1'b1, 16'h0001, 16'h0000, 4'b1101, 4'd4,  16'h0010, 1'b0, 5};
    vecs[2] = '{1'b0, 16'h00FF, 16'h0000, 4'b1001, 4'd0,  16'hFF00, 1'b0, 2};
    vecs[3] = '{1'b1, 16'h0001, 16'h0003, 4'b0000, 4'd3,  16'h000A, 1'b0, 4};
    vecs[4] = '{1'b0, 16'h8000, 16'h0001, 4'b0001, 4'd1,  16'h7FFF, 1'b1, 2};
    vecs[5] = '{1'b1, 16'h8001, 16'h0000, 4'b1111, 4'd15, 16'hC000, 1'b0, 16};
    vecs[6] = '{1'b0, 16'hFFFF, 16'h0000, 4'b1101, 4'd15, 16'h8000, 1'b1, 16};
    vecs[7] = '{1'b1, 16'h1234, 16'hFFFF, 4'b0100, 4'd2,  16'h1234, 1'b0, 3};

    reset_n = 1'b0;
    drive_req(1'b0, 1'b0, '0, '0, '0, '0);
    drive_req(1'b1, 1'b0, '0, '0, '0, '0);
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    check("reset alu_a", {16'd0, bus.alu_a}, 32'd0);
    check("reset readys", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Table-driven single operations
    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cnt,
            d, c, r, lat, ok);
      if (ok) begin
        check($sformatf("vec%0d data", i), {16'd0, d}, {16'd0, vecs[i].exp_data});
        check($sformatf("vec%0d cout", i), {31'd0, c}, {31'd0, vecs[i].exp_cout});
        check($sformatf("vec%0d id", i), {31'd0, r}, {31'd0, vecs[i].id});
        check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      end
    end
    @(posedge clk); #1;

    // Contention from reset: grants alternate 0,1,0,1 spaced cnt+2 cycles
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive_req(1'b0, 1'b1, 16'h0001, 16'h0001, 4'b0000, 4'd1);
    drive_req(1'b1, 1'b1, 16'h0002, 16'h0002, 4'b0000, 4'd1);
    n_acc = 0;
    both_ready = 0;
    for (int cyc = 0; cyc < 40 && n_acc < 4; cyc++) begin
      @(negedge clk);
      if (bus.req0_ready && bus.req1_ready) both_ready++;
      if (bus.req0_ready || bus.req1_ready) begin
        acc_ids[n_acc] = bus.req1_ready ? 1 : 0;
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
    end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, '0, '0, '0, '0);
    drive_req(1'b1, 1'b0, '0, '0, '0, '0);
    check("rr accept count", n_acc, 4);
    check("rr both ready", both_ready, 0);
    if (n_acc == 4) begin
      check("rr order", {acc_ids[0][7:0], acc_ids[1][7:0], acc_ids[2][7:0], acc_ids[3][7:0]},
            32'h00010001);
      check("rr spacing 1", acc_cyc[1] - acc_cyc[0], 3);
      check("rr spacing 3", acc_cyc[3] - acc_cyc[2], 3);
    end
    // Drain the last response
    repeat (4) @(posedge clk);
    #1;

    // Response held while rsp_ready is low; no accept in RESP
    bus.rsp_ready = 1'b0;
    do_op("hold", 1'b0, 16'h0005, 16'h0005, 4'b0000, 4'd2, d, c, r, lat, ok);
    if (ok) begin
      check("hold first data", {16'd0, d}, 32'h0000000F);
      @(posedge clk); #1;
      drive_req(1'b1, 1'b1, 16'h0100, 16'h0000, 4'b1001, 4'd1);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check($sformatf("hold data %0d", k), {16'd0, bus.rsp_data}, 32'h0000000F);
        check($sformatf("hold id %0d", k), {31'd0, bus.rsp_id}, 32'd0);
        check($sformatf("hold valid %0d", k), {31'd0, bus.rsp_valid}, 32'd1);
        check($sformatf("hold readys %0d", k), {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("hold ready before handshake", {31'd0, bus.req1_ready}, 32'd0);
      @(negedge clk);
      check("hold ready after handshake", {31'd0, bus.req1_ready}, 32'd1);
      @(posedge clk); #1;
      drive_req(1'b1, 1'b0, '0, '0, '0, '0);
      rsp_seen = 0;
      for (int k = 0; k < 10 && rsp_seen == 0; k++) begin
        @(negedge clk);
        if (bus.rsp_valid) rsp_seen = 1;
      end
      check("hold next rsp seen", rsp_seen, 1);
      check("hold next data", {16'd0, bus.rsp_data}, 32'h0000FEFF);
      check("hold next id", {31'd0, bus.rsp_id}, 32'd1);
    end
    @(posedge clk); #1;

    // Reset in the middle of a cnt=8 operation
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 16'h0000, 16'h0001, 4'b0000, 4'd8);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = bus.req0_ready;
    end
    check("rst accept seen", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst busy before", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst alu_a", {16'd0, bus.alu_a}, 32'd0);
    check("rst alu_b", {16'd0, bus.alu_b}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    rsp_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_seen++;
    end
    check("rst no response", rsp_seen, 0);
    do_op("post-reset", 1'b1, 16'h0003, 16'h0004, 4'b0000, 4'd1, d, c, r, lat, ok);
    if (ok) begin
      check("post-reset data", {16'd0, d}, 32'h00000007);
      check("post-reset id", {31'd0, r}, 32'd1);
      check("post-reset latency", lat, 2);
    end
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Shares one 16-bit combinational ALU between two requesters, with round-robin arbitration.
- Runs each accepted operation for a programmable repeat count by feeding the ALU result back into operand A. This gives multi-bit shifts and rotates from the 1-bit ALU shift ops, and repeated ADD/SUB.
- Sits between the two client ports and the ALU instance. The ALU is instantiated outside; its A/B/OP/C/Cout are wired to the alu_* ports.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- CNT_W, 4, repeat-count width.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req0_valid  input  1  client 0 request
- req0_ready  output  1  client 0 accept
- req0_a  input  WIDTH  operand A
- req0_b  input  WIDTH  operand B
- req0_op  input  4  ALU opcode
- req0_cnt  input  CNT_W  repeat count; 0 means 1
- req1_valid/req1_ready/req1_a/req1_b/req1_op/req1_cnt: same meanings and widths, client 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  WIDTH  final ALU result
- rsp_cout  output  1  OR of ALU Cout over all iterations
- rsp_id  output  1  client that issued the operation
- alu_a  output  WIDTH  to ALU A
- alu_b  output  WIDTH  to ALU B
- alu_op  output  4  to ALU OP
- alu_c  input  WIDTH  from ALU C
- alu_cout  input  1  from ALU Cout (signed overflow for ADD/SUB)
- busy  output  1  high in EXEC or RESP

Behaviour:
- Clock and reset: single clock clk; reset_n asynchronous, active-low.
- Reset values:
  - FSM=IDLE; all outputs 0.
  - last_grant=1, so client 0 wins the first contention.
  - acc, b_reg, op_reg, remaining, cout_acc = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the client not equal to last_grant.
  - reqN_ready is combinational: high only for the granted client, only in IDLE.
  - Handshake: transfer when valid & ready.
  - On transfer:
    - latch acc<=a, b_reg<=b, op_reg<=op, id<=N, cout_acc<=0, last_grant<=N;
    - remaining <= (cnt==0 ? 1 : cnt);
    - go to EXEC.
- EXEC:
  - alu_a=acc, alu_b=b_reg, alu_op=op_reg. These are the registered values, stable during EXEC.
  - Each cycle: acc<=alu_c; cout_acc<=cout_acc|alu_cout; remaining<=remaining-1.
  - When remaining==1: load rsp_data<=alu_c, rsp_cout<=cout_acc|alu_cout, rsp_id<=id, rsp_valid<=1; go to RESP.
- RESP:
  - rsp_valid held high; rsp_data/rsp_cout/rsp_id stable until rsp_valid & rsp_ready.
  - On that cycle: rsp_valid<=0; go to IDLE.
  - No request is accepted in RESP (both ready=0).
- Latency: accept at edge T; EXEC occupies cycles T+1..T+N; rsp_valid high from T+N+1. Minimum accept-to-accept spacing is N+2 cycles with rsp_ready tied high.
- alu_* outputs in IDLE/RESP: hold last registered values, no functional meaning.
- Requests: must hold valid and fields stable until ready. A requester not granted sees ready=0 and keeps waiting; no starvation with round-robin.
- cnt=max (15): 15 iterations, no counter wrap; remaining is never decremented below 1 before the exit check.
- Reset asserted in any state: the operation in flight is dropped; no response is produced; state returns to the reset values immediately.
- op values are passed through unmodified; all 16 ALU opcodes are legal with any count.

Test Plan:
- Client 0: ADD (0000), a=0x7FFF, b=0x0001, cnt=1 -> req0_ready pulses once; rsp_valid two cycles after accept; rsp_data=0x8000, rsp_cout=1, rsp_id=0.
- Client 1: op=1101 (shl), a=0x0001, cnt=4 -> rsp_data=0x0010, rsp_cout=0, rsp_id=1, rsp_valid at T+5.
- Both clients valid from reset, rsp_ready=1 -> grants in order 0,1,0,1; accept-to-accept spacing = cnt+2 cycles.
- rsp_ready low for 3 cycles in RESP -> rsp_data/rsp_id stable; both readys stay 0; IDLE only after the handshake.
- reset_n pulsed low mid-EXEC of a cnt=8 op -> all outputs 0 at once; no rsp_valid afterwards; the next request is granted normally.
- cnt=0 with op=1001 (NOT), a=0x00FF -> treated as one iteration: rsp_data=0xFF00, latency 2.
